// File: rtl/pw_ctrl_pkg.sv
// Shared definitions for the password access controller:
// state codes (also shown on the status display), state_code width,
// default digit width and the saturating failure-count helper.
package pw_ctrl_pkg;

  localparam int unsigned STATE_W        = 3;
  localparam int unsigned DIGIT_BITS_DEF = 4;

  // Code 7 is unused; the FSM recovers from it to ST_IDLE.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_CHECK = 3'd2,
    ST_OPEN  = 3'd3,
    ST_FAIL  = 3'd4,
    ST_LOCK  = 3'd5,
    ST_PROG  = 3'd6
  } state_e;

  function automatic logic [2:0] sat_inc(input logic [2:0] v, input logic [2:0] max_v);
    return (v < max_v) ? v + 3'd1 : v;
  endfunction

endpackage

// File: rtl/pw_timer.sv
// Loadable down-counter shared by the entry timeout and the lockout.
// expire is high in the last counted cycle (count == 1), so a load of N
// gives exactly N cycles before the owner acts on expire.
module pw_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_a,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == W'(1));

endmodule

// File: rtl/pw_access_ctrl.sv
// Keypad password access controller.
// Optional feature macro: ATTEMPT_LOCKOUT_EN (enables the LOCK state after
// MAX_FAIL consecutive failures). Without it LOCK is unreachable and
// locked_out stays 0; fail_cnt still counts and saturates.
module pw_access_ctrl
  import pw_ctrl_pkg::*;
#(
  parameter int unsigned Bits          = DIGIT_BITS_DEF,
  parameter int unsigned DIGITS        = 4,
  parameter logic [Bits*DIGITS-1:0] PW_DEFAULT = 16'h1234,
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned LOCK_CYCLES   = 100,
  parameter int unsigned ENTRY_TIMEOUT = 50
) (
  input  logic               clk,
  input  logic               rst_a,
  input  logic               digit_valid,
  input  logic [Bits-1:0]    digit,
  input  logic               prog_req,
  output logic               unlocked,
  output logic               locked_out,
  output logic [STATE_W-1:0] state_code,
  output logic [2:0]         digit_idx,
  output logic [2:0]         fail_cnt,
  output logic               err_pulse
);

  localparam int unsigned BUF_W   = Bits * DIGITS;
  localparam int unsigned SHD_W   = BUF_W - Bits;
  localparam int unsigned TMR_MAX = (LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

`ifdef ATTEMPT_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   ent_q, ent_d;
  logic [SHD_W-1:0]   shd_q, shd_d;
  logic [BUF_W-1:0]   pw_q, pw_d;
  logic [3:0]         idx_q, idx_d;
  logic [2:0]         fail_q, fail_d, fail_inc;
  logic               err_q, err_d;
  logic               last_digit;
  logic               tmr_load, tmr_exp;
  logic [TMR_W-1:0]   tmr_val;

  pw_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_a    (rst_a),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_exp)
  );

  // State and datapath registers; reset discards any entry or programming progress.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= ST_IDLE;
      ent_q   <= '0;
      shd_q   <= '0;
      pw_q    <= PW_DEFAULT;
      idx_q   <= '0;
      fail_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ent_q   <= ent_d;
      shd_q   <= shd_d;
      pw_q    <= pw_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  // Next-state, datapath updates and timer control.
  // The shadow buffer holds only the first DIGITS-1 digits; the final
  // digit is merged straight into the stored password on the commit cycle.
  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    shd_d      = shd_q;
    pw_d       = pw_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = TMR_W'(ENTRY_TIMEOUT);
    fail_inc   = sat_inc(fail_q, 3'(MAX_FAIL));
    last_digit = ((idx_q + 4'd1) == 4'(DIGITS));

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        if (digit_valid) begin
          ent_d    = BUF_W'({ent_q, digit});
          idx_d    = idx_q + 4'd1;
          tmr_load = 1'b1;
          state_d  = last_digit ? ST_CHECK : ST_ENTRY;
        end else if (state_q == ST_ENTRY && tmr_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          idx_d   = '0;
          ent_d   = '0;
        end
      end
      ST_CHECK: begin
        idx_d = '0;
        ent_d = '0;
        if (ent_q == pw_q) begin
          state_d = ST_OPEN;
          fail_d  = '0;
        end else begin
          state_d = ST_FAIL;
          err_d   = 1'b1;
        end
      end
      ST_FAIL: begin
        fail_d = fail_inc;
        if (LOCKOUT_EN && fail_inc == 3'(MAX_FAIL)) begin
          state_d  = ST_LOCK;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(LOCK_CYCLES);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        if (tmr_exp) begin
          state_d = ST_IDLE;
          fail_d  = '0;
        end
      end
      ST_OPEN: begin
        if (digit_valid) begin
          if (prog_req) begin
            state_d  = ST_PROG;
            shd_d    = '0;
            idx_d    = '0;
            tmr_load = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_PROG: begin
        if (digit_valid) begin
          tmr_load = 1'b1;
          if (last_digit) begin
            pw_d    = {shd_q, digit};
            shd_d   = '0;
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            shd_d = SHD_W'({shd_q, digit});
            idx_d = idx_q + 4'd1;
          end
        end else if (tmr_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          idx_d   = '0;
          shd_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign unlocked   = (state_q == ST_OPEN);
`ifdef ATTEMPT_LOCKOUT_EN
  assign locked_out = (state_q == ST_LOCK);
`else
  assign locked_out = 1'b0;
`endif
  assign state_code = state_q;
  assign digit_idx  = idx_q[2:0];
  assign fail_cnt   = fail_q;
  assign err_pulse  = err_q;

endmodule
